// File: rtl/aes_last_round_pipe.sv
// ---------------------------------------------------------------------------
// aes_last_round_pipe
//   Final AES round (no MixColumns) for both directions, feeding a small
//   output FIFO. Encrypt: AddRoundKey(ShiftRows(SubBytes(x)), enc_key[sel]).
//   Decrypt: AddRoundKey(InvSubBytes(InvShiftRows(x)), dec_key[sel]).
//   Byte 0 is data[127:120]; the state is column-major (byte r+4c = row r,
//   column c).
//
//   Optional build macro: AES_LAST_ROUND_PIPE_ZEROIZE_EN adds a zeroize input
//   that clears keys, loaded flags and FIFO (not counters).
//
// Ports
//   clk, rstn                 clock; synchronous active-high reset
//   zeroize                   (macro only) key/FIFO wipe, beats key_wr/accept
//   in_valid/in_ready         input handshake
//   in_data/in_en_de/in_key_sel/in_tag   round state, direction, slot, tag
//   key_wr/key_wr_inv/key_wr_idx/key_wr_data   key-bank write port
//   out_valid/out_ready       output handshake
//   out_data/out_en_de/out_tag/out_err   FIFO head (err = unloaded key used)
//   cnt_enc/cnt_dec           saturating accepted-packet counters
// ---------------------------------------------------------------------------

// One byte lane: forward and inverse S-box, computed algebraically
// (GF(2^8) inverse plus affine map) rather than from a 256-entry table.
module aes_sbox_lane (
  input  logic [7:0] enc_byte,
  input  logic [7:0] dec_byte,
  output logic [7:0] sub_byte,
  output logic [7:0] inv_sub_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse and maps 0 to 0, as the S-box needs.
  // 254 = 2+4+...+128, so multiply together the seven successive squares.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // s = b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // b = rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  assign sub_byte     = affine(gf_inv(enc_byte));
  assign inv_sub_byte = gf_inv(inv_affine(dec_byte));
endmodule

module aes_last_round_pipe #(
  parameter int KEY_SLOTS = 4,
  parameter int OUT_DEPTH = 2,
  parameter int TAG_W     = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
`ifdef AES_LAST_ROUND_PIPE_ZEROIZE_EN
  input  logic                         zeroize,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [127:0]                 in_data,
  input  logic                         in_en_de,
  input  logic [$clog2(KEY_SLOTS)-1:0] in_key_sel,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic                         key_wr,
  input  logic                         key_wr_inv,
  input  logic [$clog2(KEY_SLOTS)-1:0] key_wr_idx,
  input  logic [127:0]                 key_wr_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [127:0]                 out_data,
  output logic                         out_en_de,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_err,
  output logic [15:0]                  cnt_enc,
  output logic [15:0]                  cnt_dec
);
  localparam int NUM_LANES = 16;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);

  typedef struct packed {
    logic [127:0]     data;
    logic             en_de;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  // -------------------------------------------------------------------------
  // Wipe: reset or zeroize both clear keys, flags and FIFO.
  // -------------------------------------------------------------------------
  logic wipe;
`ifdef AES_LAST_ROUND_PIPE_ZEROIZE_EN
  assign wipe = rstn | zeroize;
`else
  assign wipe = rstn;
`endif

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic [CW-1:0] count;
  logic          accept;
  logic          pop;

  // Dropping in_ready during a wipe keeps the producer from seeing a transfer
  // that the block then discards.
  assign in_ready  = ~wipe & (count < DEPTH_C);
  assign accept    = in_valid & in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // Key banks
  // -------------------------------------------------------------------------
  logic [127:0]         enc_key [KEY_SLOTS];
  logic [127:0]         dec_key [KEY_SLOTS];
  logic [KEY_SLOTS-1:0] enc_ld;
  logic [KEY_SLOTS-1:0] dec_ld;

  // Datapath reads the registered key, so a same-cycle key_wr only takes
  // effect for packets accepted on later edges.
  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < KEY_SLOTS; i++) begin
        enc_key[i] <= '0;
        dec_key[i] <= '0;
      end
      enc_ld <= '0;
      dec_ld <= '0;
    end else if (key_wr) begin
      if (key_wr_inv) begin
        dec_key[key_wr_idx] <= key_wr_data;
        dec_ld[key_wr_idx]  <= 1'b1;
      end else begin
        enc_key[key_wr_idx] <= key_wr_data;
        enc_ld[key_wr_idx]  <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Round datapath. Each direction only sees in_data when it is the one
  // accepting; otherwise its input is held at zero.
  // -------------------------------------------------------------------------
  logic [127:0] enc_in;
  logic [127:0] dec_in;
  logic [127:0] sub_v;
  logic [127:0] inv_v;
  logic [127:0] enc_sr;
  logic [127:0] dec_sr;

  assign enc_in = (accept & ~in_en_de) ? in_data : '0;
  assign dec_in = (accept &  in_en_de) ? in_data : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int R  = i % 4;
    localparam int C  = i / 4;
    // Row r rotates left by r for ShiftRows, right by r for InvShiftRows.
    localparam int ES = R + 4 * ((C + R) % 4);
    localparam int DS = R + 4 * ((C + 4 - R) % 4);

    aes_sbox_lane u_lane (
      .enc_byte     (enc_in[127-8*i -: 8]),
      .dec_byte     (dec_in[127-8*i -: 8]),
      .sub_byte     (sub_v[127-8*i -: 8]),
      .inv_sub_byte (inv_v[127-8*i -: 8])
    );

    // SubBytes is bytewise, so the row shift can follow the S-box in both
    // directions.
    assign enc_sr[127-8*i -: 8] = sub_v[127-8*ES -: 8];
    assign dec_sr[127-8*i -: 8] = inv_v[127-8*DS -: 8];
  end

  res_t res;
  always_comb begin
    res       = '0;
    res.en_de = in_en_de;
    res.tag   = in_tag;
    if (in_en_de) begin
      res.data = dec_sr ^ dec_key[in_key_sel];
      res.err  = ~dec_ld[in_key_sel];
    end else begin
      res.data = enc_sr ^ enc_key[in_key_sel];
      res.err  = ~enc_ld[in_key_sel];
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO. Entries are cleared on wipe so an empty FIFO presents zeros.
  // -------------------------------------------------------------------------
  res_t          mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= res;
        wr_ptr      <= ptr_nxt(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_nxt(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  res_t head;
  assign head      = mem[rd_ptr];
  assign out_data  = head.data;
  assign out_en_de = head.en_de;
  assign out_tag   = head.tag;
  assign out_err   = head.err;

  // -------------------------------------------------------------------------
  // Counters: only reset clears them; zeroize leaves them alone.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_enc <= '0;
      cnt_dec <= '0;
    end else if (accept) begin
      if (in_en_de) begin
        if (cnt_dec != 16'hFFFF) cnt_dec <= cnt_dec + 16'd1;
      end else begin
        if (cnt_enc != 16'hFFFF) cnt_enc <= cnt_enc + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes_last_round_pipe.sv
module tb_aes_last_round_pipe;
  localparam int KEY_SLOTS = 4;
  localparam int OUT_DEPTH = 2;
  localparam int TAG_W     = 4;
  localparam int KSW       = $clog2(KEY_SLOTS);

  logic             clk = 1'b0;
  logic             rstn;
  logic             zeroize = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             in_en_de;
  logic [KSW-1:0]   in_key_sel;
  logic [TAG_W-1:0] in_tag;
  logic             key_wr;
  logic             key_wr_inv;
  logic [KSW-1:0]   key_wr_idx;
  logic [127:0]     key_wr_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_en_de;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [15:0]      cnt_enc;
  logic [15:0]      cnt_dec;

  always #5 clk = ~clk;

  aes_last_round_pipe #(.KEY_SLOTS(KEY_SLOTS), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
`ifdef AES_LAST_ROUND_PIPE_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_en_de(in_en_de), .in_key_sel(in_key_sel), .in_tag(in_tag),
    .key_wr(key_wr), .key_wr_inv(key_wr_inv), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_en_de(out_en_de), .out_tag(out_tag), .out_err(out_err),
    .cnt_enc(cnt_enc), .cnt_dec(cnt_dec)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- S-box tables from the field definition ----------------
  bit [7:0] sbox  [256];
  bit [7:0] isbox [256];

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (15'h11B << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_tables();
    bit [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] d, input logic dec,
                                               input logic [127:0] k);
    logic [7:0]   b [16];
    logic [127:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        if (!dec) begin
          src = row + 4 * ((c + row) % 4);
          r[127-8*(row+4*c) -: 8] = sbox[b[src]];
        end else begin
          src = row + 4 * ((c + 4 - row) % 4);
          r[127-8*(row+4*c) -: 8] = isbox[b[src]];
        end
      end
    return r ^ k;
  endfunction

  // ---------------- Behavioural model + per-cycle compare ----------------
  typedef struct {
    logic [127:0]     data;
    logic             en_de;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t         q[$];
  logic [127:0] m_ek [KEY_SLOTS];
  logic [127:0] m_dk [KEY_SLOTS];
  bit           m_el [KEY_SLOTS];
  bit           m_dl [KEY_SLOTS];
  logic [15:0]  m_ce = '0;
  logic [15:0]  m_cd = '0;

  task automatic model_wipe();
    q.delete();
    for (int i = 0; i < KEY_SLOTS; i++) begin
      m_ek[i] = '0; m_dk[i] = '0; m_el[i] = 0; m_dl[i] = 0;
    end
  endtask

  // Inputs change only just after a rising edge, so the values seen here are
  // exactly what the next rising edge samples: compare first, then advance
  // the model by that edge.
  always @(negedge clk) begin
    exp_t e;
    bit   acc, popq;
    check("in_ready", in_ready, !rstn && !zeroize && (q.size() < OUT_DEPTH));
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_en_de", out_en_de, q[0].en_de);
      check("out_tag", out_tag, q[0].tag);
      check("out_err", out_err, q[0].err);
    end
    check("cnt_enc", cnt_enc, m_ce);
    check("cnt_dec", cnt_dec, m_cd);

    if (rstn || zeroize) begin
      model_wipe();
      if (rstn) begin m_ce = '0; m_cd = '0; end
    end else begin
      acc  = in_valid && (q.size() < OUT_DEPTH);
      popq = (q.size() != 0) && out_ready;
      if (acc) begin
        e.data  = model_round(in_data, in_en_de,
                              in_en_de ? m_dk[in_key_sel] : m_ek[in_key_sel]);
        e.en_de = in_en_de;
        e.tag   = in_tag;
        e.err   = in_en_de ? !m_dl[in_key_sel] : !m_el[in_key_sel];
      end
      if (popq) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (in_en_de) begin if (m_cd != 16'hFFFF) m_cd = m_cd + 16'd1; end
        else          begin if (m_ce != 16'hFFFF) m_ce = m_ce + 16'd1; end
      end
      if (key_wr) begin
        if (key_wr_inv) begin m_dk[key_wr_idx] = key_wr_data; m_dl[key_wr_idx] = 1; end
        else            begin m_ek[key_wr_idx] = key_wr_data; m_el[key_wr_idx] = 1; end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic inv, input logic [KSW-1:0] idx, input logic [127:0] k);
    key_wr = 1; key_wr_inv = inv; key_wr_idx = idx; key_wr_data = k;
    step();
    key_wr = 0;
  endtask

  task automatic send(input logic ed, input logic [KSW-1:0] sel, input logic [127:0] d,
                      input logic [TAG_W-1:0] t);
    in_valid = 1; in_en_de = ed; in_key_sel = sel; in_data = d; in_tag = t;
    check("send_ready", in_ready, 1'b1);
    step();
    in_valid = 0;
  endtask

  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] ALL9C = {16{8'h9C}};
  localparam logic [127:0] ALL52 = {16{8'h52}};
  localparam logic [127:0] ONES  = {128{1'b1}};

  logic [TAG_W-1:0] tags [3];
  int               got;
  bit               acc_now;

  initial begin
    build_tables();
    model_wipe();
    // Known S-box entries pin the model tables.
    check("sbox_00", sbox[8'h00], 8'h63);
    check("sbox_01", sbox[8'h01], 8'h7C);
    check("sbox_53", sbox[8'h53], 8'hED);
    check("sbox_ff", sbox[8'hFF], 8'h16);
    check("isbox_00", isbox[8'h00], 8'h52);

    rstn = 1; in_valid = 0; in_data = '0; in_en_de = 0; in_key_sel = '0; in_tag = '0;
    key_wr = 0; key_wr_inv = 0; key_wr_idx = '0; key_wr_data = '0; out_ready = 1;
    step(); step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_tag", out_tag, '0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_out_en_de", out_en_de, 1'b0);
    check("rst_cnt", {cnt_enc, cnt_dec}, '0);
    rstn = 0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);

    // Loaded enc slot 1 = all ones: 63 ^ FF = 9C.
    load_key(0, 1, ONES);
    send(0, 1, '0, 4'd1);
    check("k1_valid", out_valid, 1'b1);
    check("k1_data", out_data, ALL9C);
    check("k1_err", out_err, 1'b0);
    check("k1_cnt", cnt_enc, 16'd1);

    // Never-loaded slot 0: zero key, flagged.
    send(0, 0, '0, 4'd2);
    check("k0_data", out_data, ALL63);
    check("k0_err", out_err, 1'b1);
    check("k0_cnt", cnt_enc, 16'd2);

    // Decrypt with loaded zero key in slot 2.
    load_key(1, 2, '0);
    send(1, 2, '0, 4'd3);
    check("d2_data", out_data, ALL52);
    check("d2_en_de", out_en_de, 1'b1);
    check("d2_err", out_err, 1'b0);
    check("d2_cnt", cnt_dec, 16'd1);

    // Key write in the acceptance cycle: old key applies to this packet.
    key_wr = 1; key_wr_inv = 0; key_wr_idx = 0; key_wr_data = ONES;
    send(0, 0, '0, 4'd4);
    key_wr = 0;
    check("kw_same_data", out_data, ALL63);
    check("kw_same_err", out_err, 1'b1);
    send(0, 0, '0, 4'd5);
    check("kw_next_data", out_data, ALL9C);
    check("kw_next_err", out_err, 1'b0);

    // Varied data and keys, checked by the model.
    load_key(0, 2, 128'h000102030405060708090a0b0c0d0e0f);
    load_key(1, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    load_key(1, 1, 128'hdeadbeef0123456789abcdeffedcba98);
    send(0, 2, 128'h00112233445566778899aabbccddeeff, 4'd6);
    send(1, 0, 128'h00112233445566778899aabbccddeeff, 4'd7);
    send(1, 1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd8);
    send(0, 3, 128'h3243f6a8885a308d313198a2e0370734, 4'd9);
    send(1, 3, 128'h0f0e0d0c0b0a09080706050403020100, 4'd10);

    for (int k = 0; k < 60; k++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_en_de    = 1'($urandom_range(0, 1));
      in_key_sel  = KSW'($urandom_range(0, KEY_SLOTS - 1));
      in_data     = {$urandom, $urandom, $urandom, $urandom};
      in_tag      = TAG_W'($urandom);
      out_ready   = 1'($urandom_range(0, 1));
      key_wr      = ($urandom_range(0, 7) == 0);
      key_wr_inv  = 1'($urandom_range(0, 1));
      key_wr_idx  = KSW'($urandom_range(0, KEY_SLOTS - 1));
      key_wr_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 0; key_wr = 0; out_ready = 1;
    step(); step(); step();

    // Back-pressure: fill, stall, then drain in order.
    out_ready = 0;
    in_valid = 1; in_en_de = 0; in_key_sel = 1; in_data = 128'hcafef00d; in_tag = 4'd0;
    step();
    in_tag = 4'd1;
    step();
    check("full_ready", in_ready, 1'b0);
    in_tag = 4'd2;
    step(); step();
    check("full_ready_hold", in_ready, 1'b0);
    check("full_head_tag", out_tag, 4'd0);
    out_ready = 1;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      acc_now = in_valid && in_ready;
      if (out_valid) begin tags[got] = out_tag; got++; end
      step();
      if (acc_now) in_valid = 0;
    end
    in_valid = 0;
    check("drain_count", got, 3);
    check("drain_tag0", tags[0], 4'd0);
    check("drain_tag1", tags[1], 4'd1);
    check("drain_tag2", tags[2], 4'd2);

    // Mid-operation reset drops queued data, in_valid and key_wr.
    out_ready = 0;
    send(0, 1, 128'h1234, 4'd7);
    rstn = 1; in_valid = 1; in_en_de = 0; in_key_sel = 3;
    key_wr = 1; key_wr_inv = 0; key_wr_idx = 3; key_wr_data = ONES;
    step();
    rstn = 0; in_valid = 0; key_wr = 0;
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_cnt", cnt_enc, 16'd0);
    send(0, 3, '0, 4'd8);
    check("mrst_k3_data", out_data, ALL63);
    check("mrst_k3_err", out_err, 1'b1);
    check("mrst_k3_cnt", cnt_enc, 16'd1);
    out_ready = 1;
    step(); step();

`ifdef AES_LAST_ROUND_PIPE_ZEROIZE_EN
    load_key(0, 1, ONES);
    out_ready = 0;
    send(0, 1, '0, 4'd9);
    send(0, 1, '0, 4'd10);
    zeroize = 1;
    step();
    zeroize = 0;
    #1;
    check("zz_out_valid", out_valid, 1'b0);
    check("zz_cnt", cnt_enc, 16'd3);
    send(0, 1, '0, 4'd11);
    check("zz_k1_err", out_err, 1'b1);
    check("zz_k1_data", out_data, ALL63);
    check("zz_k1_cnt", cnt_enc, 16'd4);
    out_ready = 1;
    step(); step();
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
